// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared types and constants for the PC fetch controller.
// Latency: n/a (package only).
// Backpressure: n/a.
package pc_fetch_ctrl_pkg;

    // Fetch sequencer states: BOOT after reset, REQ while a fetch is outstanding,
    // HOLD while a fetched instruction waits for decode.
    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

endpackage

// File: rtl/pc_redirect_buf.sv
// Pending-redirect buffer plus optional target alignment fix-up (macro PC_ALIGN_CHECK_EN).
// Latency: fixed target is combinational; pend/pend_target/align_err register on clk.
// Backpressure: a redirect arriving mid-fetch is parked until the fetch acks; last one wins.
module pc_redirect_buf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redir_valid,
    input  logic [31:0] redir_target,
    input  logic        in_req,
    input  logic        imem_ack,
    output logic [31:0] target_fixed,
    output logic        pend,
    output logic [31:0] pend_target,
    output logic        align_err
);

    logic pend_load;
    logic pend_clear;

    // A redirect can only be parked while the memory still owns the fetch;
    // any ack in REQ retires the pending entry (used or superseded).
    assign pend_load  = in_req && redir_valid && !imem_ack;
    assign pend_clear = in_req && imem_ack;

`ifdef PC_ALIGN_CHECK_EN
    assign target_fixed = {redir_target[31:2], 2'b00};

    // Sticky flag: any misaligned redirect is remembered until reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            align_err <= 1'b0;
        end else if (redir_valid && (redir_target[1:0] != 2'b00)) begin
            align_err <= 1'b1;
        end
    end
`else
    assign target_fixed = redir_target;
    assign align_err    = 1'b0;
`endif

    // Park or retire the deferred redirect target.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend        <= 1'b0;
            pend_target <= 32'd0;
        end else if (pend_load) begin
            pend        <= 1'b1;
            pend_target <= target_fixed;
        end else if (pend_clear) begin
            pend        <= 1'b0;
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Instruction fetch PC sequencer with redirect handling; alignment check via PC_ALIGN_CHECK_EN.
// Latency: one fetch per REQ->ack, instruction presented the cycle after ack, held until if_ready.
// Backpressure: if_ready low holds the instruction in HOLD; imem_ack low stalls in REQ with pc fixed.
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] pc,
    input  logic [31:0] pc_plus4,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] instr_rdata,
    input  logic        redir_valid,
    input  logic [31:0] redir_target,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        align_err
);

    fetch_state_t state;
    fetch_state_t state_nxt;
    logic [31:0]  pc_nxt;
    logic         if_valid_nxt;
    logic [31:0]  if_instr_nxt;
    logic [31:0]  if_pc_nxt;
    logic [31:0]  target_fixed;
    logic         pend;
    logic [31:0]  pend_target;

    pc_redirect_buf u_redir_buf (
        .clk          (clk),
        .rst_n        (rst_n),
        .redir_valid  (redir_valid),
        .redir_target (redir_target),
        .in_req       (state == ST_REQ),
        .imem_ack     (imem_ack),
        .target_fixed (target_fixed),
        .pend         (pend),
        .pend_target  (pend_target),
        .align_err    (align_err)
    );

    // Next-state and output decode; redirects always win over ack and if_ready.
    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        if_valid_nxt = if_valid;
        if_instr_nxt = if_instr;
        if_pc_nxt    = if_pc;
        imem_req     = 1'b0;
        case (state)
            ST_BOOT: begin
                state_nxt = ST_REQ;
                if (redir_valid) begin
                    pc_nxt = target_fixed;
                end
            end
            ST_REQ: begin
                imem_req = 1'b1;
                if (redir_valid) begin
                    // Without ack the redirect is parked in the buffer; pc stays put.
                    if (imem_ack) begin
                        pc_nxt = target_fixed;
                    end
                end else if (imem_ack) begin
                    if (pend) begin
                        // Word belongs to the stale path; refetch from the parked target.
                        pc_nxt = pend_target;
                    end else begin
                        if_instr_nxt = instr_rdata;
                        if_pc_nxt    = pc;
                        pc_nxt       = pc_plus4;
                        if_valid_nxt = 1'b1;
                        state_nxt    = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (redir_valid) begin
                    pc_nxt       = target_fixed;
                    if_valid_nxt = 1'b0;
                    state_nxt    = ST_REQ;
                end else if (if_ready) begin
                    if_valid_nxt = 1'b0;
                    state_nxt    = ST_REQ;
                end
            end
            default: begin
                state_nxt = ST_BOOT;
            end
        endcase
    end

    // State and fetch-stage registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_BOOT;
            pc       <= RESET_PC;
            if_valid <= 1'b0;
            if_instr <= 32'd0;
            if_pc    <= 32'd0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            if_valid <= if_valid_nxt;
            if_instr <= if_instr_nxt;
            if_pc    <= if_pc_nxt;
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios plus randomized traffic vs a reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_pc_fetch_ctrl;

    localparam logic [31:0] RST_PC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] instr_rdata;
    logic        redir_valid;
    logic [31:0] redir_target;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        align_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // External incrementer.
    assign pc_plus4 = pc + 32'd4;

    pc_fetch_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .imem_req     (imem_req),
        .imem_ack     (imem_ack),
        .instr_rdata  (instr_rdata),
        .redir_valid  (redir_valid),
        .redir_target (redir_target),
        .if_valid     (if_valid),
        .if_ready     (if_ready),
        .if_instr     (if_instr),
        .if_pc        (if_pc),
        .align_err    (align_err)
    );

    // Reference model: phase 0 = idle after reset, 1 = waiting for memory, 2 = holding for decode.
    int          m_ph;
    logic [31:0] m_pc, m_ptgt, m_ifpc, m_ifinstr;
    logic        m_pend, m_ifv, m_aerr;
    bit          sb_en = 1'b0;

    function automatic logic [31:0] fix_t(input logic [31:0] t);
`ifdef PC_ALIGN_CHECK_EN
        return {t[31:2], 2'b00};
`else
        return t;
`endif
    endfunction

    always @(posedge clk) begin : model_blk
        logic [31:0] t;
        if (!rst_n) begin
            m_ph = 0; m_pc = RST_PC; m_pend = 1'b0; m_ptgt = 32'd0;
            m_ifv = 1'b0; m_ifpc = 32'd0; m_ifinstr = 32'd0; m_aerr = 1'b0;
        end else if (redir_valid) begin
            t = fix_t(redir_target);
`ifdef PC_ALIGN_CHECK_EN
            if (redir_target[1:0] != 2'b00) m_aerr = 1'b1;
`endif
            if (m_ph == 1 && !imem_ack) begin
                m_pend = 1'b1; m_ptgt = t;
            end else begin
                m_pc = t; m_ifv = 1'b0; m_ph = 1; m_pend = 1'b0;
            end
        end else begin
            case (m_ph)
                0: m_ph = 1;
                1: if (imem_ack) begin
                       if (m_pend) begin
                           m_pc = m_ptgt; m_pend = 1'b0;
                       end else begin
                           m_ifinstr = instr_rdata; m_ifpc = m_pc;
                           m_pc = m_pc + 32'd4; m_ifv = 1'b1; m_ph = 2;
                       end
                   end
                default: if (if_ready) begin
                       m_ifv = 1'b0; m_ph = 1;
                   end
            endcase
        end
    end

    // Scoreboard: compare every visible output against the model mid-cycle.
    always @(negedge clk) begin
        if (sb_en) begin
            n_checks++;
            if ({pc, imem_req, if_valid, if_pc, if_instr, align_err} !==
                {m_pc, (m_ph == 1), m_ifv, m_ifpc, m_ifinstr, m_aerr}) begin
                n_fail++;
                $display("FAIL scoreboard t=%0t got pc=%h req=%b v=%b ifpc=%h instr=%h aerr=%b want pc=%h req=%b v=%b ifpc=%h instr=%h aerr=%b",
                         $time, pc, imem_req, if_valid, if_pc, if_instr, align_err,
                         m_pc, (m_ph == 1), m_ifv, m_ifpc, m_ifinstr, m_aerr);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ph(input int p);
        int k = 0;
        while (m_ph != p && k < 20) begin
            cyc();
            k++;
        end
        if (m_ph != p) begin
            n_checks++; n_fail++;
            $display("FAIL wait_state timeout got phase=%0d want=%0d", m_ph, p);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; imem_ack = 1'b1; redir_valid = 1'b1; redir_target = 32'h1234_5678;
        instr_rdata = $urandom; if_ready = 1'b1;
        cyc(); cyc();
        sb_en = 1'b1;
        redir_valid = 1'b0;
        n_checks++; if (pc !== RST_PC) begin n_fail++; $display("FAIL reset_pc got=%h want=%h", pc, RST_PC); end
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%b want=0", imem_req); end
        n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b want=0", if_valid); end
        n_checks++; if (if_pc !== 32'd0) begin n_fail++; $display("FAIL reset_ifpc got=%h want=0", if_pc); end
        n_checks++; if (if_instr !== 32'd0) begin n_fail++; $display("FAIL reset_instr got=%h want=0", if_instr); end
        n_checks++; if (align_err !== 1'b0) begin n_fail++; $display("FAIL reset_aerr got=%b want=0", align_err); end
    endtask

    task automatic test_sequential();
        logic [31:0] got[$];
        int back2back = 0;
        logic prev_v = 1'b0;
        logic [31:0] exp_pc;
        if_ready = 1'b1; imem_ack = 1'b1; rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            instr_rdata = $urandom;
            cyc();
            if (if_valid) got.push_back(if_pc);
            if (if_valid && prev_v) back2back++;
            prev_v = if_valid;
        end
        if_ready = 1'b0; imem_ack = 1'b0;
        n_checks++; if (got.size() != 4) begin n_fail++; $display("FAIL seq_count got=%0d want=4", got.size()); end
        n_checks++; if (back2back != 0) begin n_fail++; $display("FAIL seq_alternate got=%0d want=0", back2back); end
        for (int i = 0; i < 3; i++) begin
            exp_pc = RST_PC + 32'(4 * i);
            n_checks++;
            if (i >= got.size() || got[i] !== exp_pc) begin
                n_fail++;
                $display("FAIL seq_ifpc%0d got=%h want=%h", i, (i < got.size()) ? got[i] : 32'hx, exp_pc);
            end
        end
    endtask

    task automatic test_redirect_hold();
        if_ready = 1'b0; imem_ack = 1'b1;
        wait_ph(2);
        imem_ack = 1'b0;
        cyc();
        n_checks++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid got=%b want=1", if_valid); end
        redir_valid = 1'b1; redir_target = 32'h0040_0100; if_ready = 1'b1;
        cyc();
        redir_valid = 1'b0; if_ready = 1'b0;
        n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL hredir_valid got=%b want=0", if_valid); end
        n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL hredir_req got=%b want=1", imem_req); end
        n_checks++; if (pc !== 32'h0040_0100) begin n_fail++; $display("FAIL hredir_pc got=%h want=00400100", pc); end
        imem_ack = 1'b1; instr_rdata = $urandom;
        cyc();
        imem_ack = 1'b0;
        n_checks++; if (if_pc !== 32'h0040_0100 || if_valid !== 1'b1) begin
            n_fail++; $display("FAIL hredir_ifpc got=%h/%b want=00400100/1", if_pc, if_valid);
        end
    endtask

    task automatic test_pend();
        logic [31:0] p0;
        if_ready = 1'b1;
        cyc();
        if_ready = 1'b0;
        p0 = RST_PC + 32'h104;
        imem_ack = 1'b0; redir_valid = 1'b1; redir_target = 32'h0040_0200;
        cyc();
        redir_target = 32'h0040_0300;
        cyc();
        redir_valid = 1'b0;
        cyc();
        n_checks++; if (pc !== p0 || imem_req !== 1'b1) begin
            n_fail++; $display("FAIL pend_wait got pc=%h req=%b want pc=%h req=1", pc, imem_req, p0);
        end
        imem_ack = 1'b1; instr_rdata = $urandom;
        cyc();
        n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL pend_discard got=%b want=0", if_valid); end
        n_checks++; if (pc !== 32'h0040_0300 || imem_req !== 1'b1) begin
            n_fail++; $display("FAIL pend_pc got pc=%h req=%b want 00400300/1", pc, imem_req);
        end
        instr_rdata = $urandom;
        cyc();
        imem_ack = 1'b0;
        n_checks++; if (if_pc !== 32'h0040_0300 || if_valid !== 1'b1) begin
            n_fail++; $display("FAIL pend_ifpc got=%h/%b want=00400300/1", if_pc, if_valid);
        end
    endtask

    task automatic test_wrap();
        redir_valid = 1'b1; redir_target = 32'hFFFF_FFFC;
        cyc();
        redir_valid = 1'b0; imem_ack = 1'b1; instr_rdata = $urandom;
        cyc();
        imem_ack = 1'b0;
        n_checks++; if (if_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_ifpc got=%h want=fffffffc", if_pc); end
        n_checks++; if (pc !== 32'd0) begin n_fail++; $display("FAIL wrap_pc got=%h want=0", pc); end
        if_ready = 1'b1;
        cyc();
        if_ready = 1'b0;
        n_checks++; if (pc !== 32'd0 || imem_req !== 1'b1) begin
            n_fail++; $display("FAIL wrap_req got pc=%h req=%b want 0/1", pc, imem_req);
        end
    endtask

    task automatic test_align();
        logic [31:0] exp_pc;
        logic        exp_err;
`ifdef PC_ALIGN_CHECK_EN
        exp_pc = 32'h0040_0100; exp_err = 1'b1;
`else
        exp_pc = 32'h0040_0102; exp_err = 1'b0;
`endif
        redir_valid = 1'b1; redir_target = 32'h0040_0102; imem_ack = 1'b1;
        cyc();
        redir_valid = 1'b0; imem_ack = 1'b0;
        n_checks++; if (pc !== exp_pc) begin n_fail++; $display("FAIL align_pc got=%h want=%h", pc, exp_pc); end
        n_checks++; if (align_err !== exp_err) begin n_fail++; $display("FAIL align_err got=%b want=%b", align_err, exp_err); end
        redir_valid = 1'b1; redir_target = 32'h0040_0200;
        cyc();
        redir_valid = 1'b0;
        cyc(); cyc();
        n_checks++; if (align_err !== exp_err) begin n_fail++; $display("FAIL align_sticky got=%b want=%b", align_err, exp_err); end
    endtask

    task automatic test_reset_mid();
        wait_ph(1);
        imem_ack = 1'b0; redir_valid = 1'b1; redir_target = 32'h0040_0500;
        cyc();
        redir_valid = 1'b0;
        rst_n = 1'b0; imem_ack = 1'b1;
        cyc();
        n_checks++; if (pc !== RST_PC) begin n_fail++; $display("FAIL rmid_pc got=%h want=%h", pc, RST_PC); end
        n_checks++; if (imem_req !== 1'b0 || if_valid !== 1'b0) begin
            n_fail++; $display("FAIL rmid_boot got req=%b v=%b want 0/0", imem_req, if_valid);
        end
        n_checks++; if (align_err !== 1'b0) begin n_fail++; $display("FAIL rmid_aerr got=%b want=0", align_err); end
        rst_n = 1'b1; instr_rdata = $urandom;
        cyc(); cyc();
        imem_ack = 1'b0;
        n_checks++; if (if_valid !== 1'b1 || if_pc !== RST_PC) begin
            n_fail++; $display("FAIL rmid_pend_clr got v=%b ifpc=%h want 1/%h", if_valid, if_pc, RST_PC);
        end
    endtask

    task automatic test_random();
        logic [31:0] t;
        for (int i = 0; i < 800; i++) begin
            imem_ack    = 1'($urandom % 2);
            if_ready    = 1'($urandom % 2);
            redir_valid = ($urandom % 6 == 0);
            t = $urandom;
            if ($urandom % 2 == 0) t[1:0] = 2'b00;
            if ($urandom % 8 == 0) t = 32'hFFFF_FFF8 + 32'($urandom % 2) * 4;
            redir_target = t;
            instr_rdata  = $urandom;
            rst_n        = ($urandom % 80 != 0);
            cyc();
        end
        rst_n = 1'b1; redir_valid = 1'b0; imem_ack = 1'b0; if_ready = 1'b0;
        cyc();
    endtask

    initial begin
        rst_n = 1'b0; redir_valid = 1'b0; redir_target = 32'd0;
        imem_ack = 1'b0; instr_rdata = 32'd0; if_ready = 1'b0;
        test_reset();
        test_sequential();
        test_redirect_hold();
        test_pend();
        test_wrap();
        test_align();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0040_0000, SHALL be the PC value loaded on reset.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 pc  output  32  current fetch address; drives the external PC+4 incrementer and the instruction memory.
REQ-005 pc_plus4  input  32  incrementer result, combinational from pc.
REQ-006 imem_req  output  1  fetch request at address pc.
REQ-007 imem_ack  input  1  instr_rdata valid this cycle; request complete.
REQ-008 instr_rdata  input  32  fetched word.
REQ-009 redir_valid  input  1  single-cycle redirect (branch/jump/jr/jal) pulse.
REQ-010 redir_target  input  32  redirect address.
REQ-011 if_valid  output  1  if_instr/if_pc hold a fetched instruction.
REQ-012 if_ready  input  1  decode accepts the instruction.
REQ-013 if_instr  output  32; if_pc  output  32  the instruction and its address.
REQ-014 align_err  output  1  sticky misaligned-target flag.

Function
REQ-015 FSM states SHALL be BOOT, REQ and HOLD; reset enters BOOT.
REQ-016 BOOT: imem_req=0, if_valid=0; next state REQ unconditionally.
REQ-017 REQ: imem_req=1, pc SHALL stay constant until imem_ack.
REQ-018 REQ with imem_ack and no pending redirect: if_instr<=instr_rdata, if_pc<=pc, pc<=pc_plus4, if_valid<=1, next HOLD.
REQ-019 HOLD: if_valid=1, imem_req=0; on if_ready: if_valid<=0, next REQ; otherwise outputs held unchanged.
REQ-020 Redirect in BOOT or HOLD: pc<=redir_target, if_valid<=0, next REQ; a held instruction SHALL be discarded even if if_ready is high in the same cycle.
REQ-021 Redirect in REQ with imem_ack in the same cycle: returned word discarded, pc<=redir_target, stay REQ, if_valid stays 0.
REQ-022 Redirect in REQ without imem_ack: pend<=1, pend_target<=redir_target, pc unchanged; a later redirect before ack SHALL overwrite pend_target (last wins).
REQ-023 REQ with imem_ack and pend=1: word discarded, pc<=pend_target, pend<=0, stay REQ.
REQ-024 pc arithmetic SHALL wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 0); no overflow flag.
REQ-025 Redirect SHALL take priority over if_ready and imem_ack in every state.

Reset
REQ-026 When rst_n=0 at a clock edge: pc<=RESET_PC, if_pc<=0, if_instr<=0, if_valid<=0, pend<=0, pend_target<=0, align_err<=0, state<=BOOT; this SHALL override any in-flight fetch or redirect.

Configuration
REQ-027 With PC_ALIGN_CHECK_EN defined, any accepted redirect with target[1:0]!=0 SHALL set align_err=1 (sticky until reset) and load target with bits [1:0] forced to 0.
REQ-028 Without PC_ALIGN_CHECK_EN, targets SHALL be used unmodified and align_err SHALL be tied 0.

Structure
REQ-029 Shared package SHALL hold the FSM state encoding (BOOT/REQ/HOLD) and the RESET_PC default constant.
REQ-030 A sub-module pc_redirect_buf SHALL implement pend/pend_target and the alignment fix-up; the incrementer stays external.

Verification
REQ-031 Reset release, imem_ack every REQ cycle, if_ready=1: if_pc sequence 0x00400000, 0x00400004, 0x00400008; if_valid high every other cycle.
REQ-032 Redirect to 0x00400100 while HOLD with if_ready=0: held instruction dropped, next imem_req at pc=0x00400100, next if_pc=0x00400100.
REQ-033 REQ with imem_ack low 3 cycles, redirects to 0x00400200 then 0x00400300 during the wait: ack word discarded, next request at 0x00400300.
REQ-034 pc=0xFFFFFFFC fetched and accepted: next pc=0x00000000.
REQ-035 PC_ALIGN_CHECK_EN defined, redirect to 0x00400102: pc=0x00400100, align_err=1 until rst_n=0; macro undefined: pc=0x00400102, align_err=0.
REQ-036 rst_n=0 asserted mid-REQ with pend=1: next cycle pc=RESET_PC, state BOOT, if_valid=0, pend=0.
